// File: rtl/multiply_mat_seq_pkg.sv
// multiply_mat_seq_pkg: shared state type and width helpers for the matrix multiplier
package multiply_mat_seq_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  function automatic int acc_width(int n_bits_a, int n_bits_b, int width_b);
    return n_bits_a + n_bits_b + width_b;
  endfunction
  function automatic int out_width(int n_bits_a, int n_bits_b, int width_b, int frac_shift);
    return acc_width(n_bits_a, n_bits_b, width_b) - frac_shift;
  endfunction
  function automatic int cnt_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multiply_mat_seq_mac.sv
// mac_lane: one signed multiply-accumulate lane with a synchronous clear
module mac_lane #(
  parameter int N_BITS_A = 32,
  parameter int N_BITS_B = 32,
  parameter int ACC_W = 67
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic signed [N_BITS_A-1:0] a,
  input  logic signed [N_BITS_B-1:0] b,
  output logic signed [ACC_W-1:0]    sum
);
  logic signed [ACC_W-1:0] acc;
  assign sum = acc + ACC_W'(a) * ACC_W'(b);
  // clear has priority so a finished dot product never leaks into the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/multiply_mat_seq.sv
// multiply_mat_seq: sequential signed matrix multiplier with N_LANES parallel MAC lanes
module multiply_mat_seq
  import multiply_mat_seq_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int SIZE_C = 8,
  parameter int N_BITS_A = 32,
  parameter int N_BITS_B = 32,
  parameter int WIDTH_B = 3,
  parameter int N_LANES = 2,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic signed [N_BITS_A-1:0] mat_a [SIZE_A][SIZE_B],
  input  logic signed [N_BITS_B-1:0] mat_b [SIZE_B][SIZE_C],
  output logic                       busy,
  output logic                       done,
  output logic signed [out_width(N_BITS_A, N_BITS_B, WIDTH_B, FRAC_SHIFT)-1:0] mat_out [SIZE_A][SIZE_C]
);
  localparam int ACC_W = acc_width(N_BITS_A, N_BITS_B, WIDTH_B);
  localparam int OUT_W = out_width(N_BITS_A, N_BITS_B, WIDTH_B, FRAC_SHIFT);
  localparam int N_GRP = SIZE_C / N_LANES;
  localparam int IW = cnt_width(SIZE_A);
  localparam int KW = cnt_width(SIZE_B);
  localparam int GW = cnt_width(N_GRP);
  localparam int CW = cnt_width(SIZE_C);
  localparam logic signed [ACC_W-1:0] RND =
    (ROUND != 0 && FRAC_SHIFT > 0) ? ACC_W'(1) << (FRAC_SHIFT > 0 ? FRAC_SHIFT - 1 : 0) : '0;
  state_t state, state_nx;
  logic [IW-1:0] i;
  logic [KW-1:0] k;
  logic [GW-1:0] g;
  logic k_last, g_last, i_last, cap, step, lane_clr;
  logic signed [N_BITS_A-1:0] a_r [SIZE_A][SIZE_B];
  logic signed [N_BITS_B-1:0] b_r [SIZE_B][SIZE_C];
  logic signed [ACC_W-1:0] res [SIZE_A][SIZE_C];
  logic signed [ACC_W-1:0] lane_sum [N_LANES];
  logic [CW-1:0] col [N_LANES];
  assign k_last = k == KW'(SIZE_B - 1);
  assign g_last = g == GW'(N_GRP - 1);
  assign i_last = i == IW'(SIZE_A - 1);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and control strobes; abort only matters while accumulating
  always_comb begin
    state_nx = state;
    cap = 1'b0;
    step = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: begin
        cap = start;
        state_nx = start ? MAC : IDLE;
      end
      MAC: begin
        step = !abort;
        state_nx = abort ? IDLE : (k_last && g_last && i_last) ? DONE : MAC;
      end
      default: state_nx = IDLE;
    endcase
    lane_clr = cap || (state == MAC && (abort || k_last));
  end
  // row / column-group / k counters, k innermost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i <= '0;
      k <= '0;
      g <= '0;
    end else if (cap) begin
      i <= '0;
      k <= '0;
      g <= '0;
    end else if (step) begin
      k <= k_last ? '0 : k + 1'b1;
      if (k_last) g <= g_last ? '0 : g + 1'b1;
      if (k_last && g_last) i <= i_last ? '0 : i + 1'b1;
    end
  // operand snapshot so the inputs are free to change during the run
  always_ff @(posedge clk)
    if (cap) begin
      a_r <= mat_a;
      b_r <= mat_b;
    end
  // each lane deposits its finished dot product into the result buffer
  always_ff @(posedge clk)
    if (step && k_last)
      for (int l = 0; l < N_LANES; l++) res[i][col[l]] <= lane_sum[l];
  // publish the whole rescaled result in the DONE cycle, done pulses alongside
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done <= 1'b0;
      for (int r = 0; r < SIZE_A; r++)
        for (int c = 0; c < SIZE_C; c++) mat_out[r][c] <= '0;
    end else begin
      done <= state == DONE;
      if (state == DONE)
        for (int r = 0; r < SIZE_A; r++)
          for (int c = 0; c < SIZE_C; c++) mat_out[r][c] <= OUT_W'((res[r][c] + RND) >>> FRAC_SHIFT);
    end
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign col[l] = CW'(int'(g) * N_LANES + l);
    mac_lane #(
      .N_BITS_A(N_BITS_A),
      .N_BITS_B(N_BITS_B),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .en(step),
      .clr(lane_clr),
      .a(a_r[i][k]),
      .b(b_r[k][col[l]]),
      .sum(lane_sum[l])
    );
  end
endmodule

// File: tb/tb_multiply_mat_seq.sv
// tb_multiply_mat_seq: directed vectors against a cycle-count model of the multiplier
module tb_multiply_mat_seq;
  localparam int SA = 2, SB = 2, SC = 4, NA = 8, NB = 8, WB = 1, NL = 2, FS = 4, RD = 1;
  localparam int L = SA * (SC / NL) * SB;
  localparam int OW = NA + NB + WB - FS;
  logic clk = 1'b0;
  logic rst, start, abort, busy, done;
  logic signed [NA-1:0] mat_a [SA][SB];
  logic signed [NB-1:0] mat_b [SB][SC];
  logic signed [OW-1:0] mat_out [SA][SC];
  logic signed [NA-1:0] cap_a [SA][SB];
  logic signed [NB-1:0] cap_b [SB][SC];
  logic signed [OW-1:0] exp_out [SA][SC];
  logic m_done;
  int rem;
  int checks = 0;
  int errors = 0;
  int lat, dn, d1, d2;

  multiply_mat_seq #(
    .SIZE_A(SA), .SIZE_B(SB), .SIZE_C(SC), .N_BITS_A(NA), .N_BITS_B(NB),
    .WIDTH_B(WB), .N_LANES(NL), .FRAC_SHIFT(FS), .ROUND(RD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mat_a(mat_a), .mat_b(mat_b), .busy(busy), .done(done), .mat_out(mat_out)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endfunction

  function automatic logic signed [OW-1:0] model_el(int r, int c);
    int s = 0;
    for (int q = 0; q < SB; q++) s += int'(cap_a[r][q]) * int'(cap_b[q][c]);
    return OW'((s + (RD != 0 ? 1 << (FS - 1) : 0)) >>> FS);
  endfunction

  // a run occupies L+1 busy cycles; abort only counts while more than the DONE cycle remains
  always @(posedge clk or posedge rst)
    if (rst) begin
      rem <= 0;
      m_done <= 1'b0;
      for (int r = 0; r < SA; r++)
        for (int c = 0; c < SC; c++) exp_out[r][c] <= '0;
    end else begin
      m_done <= 1'b0;
      if (rem == 0) begin
        if (start) begin
          cap_a <= mat_a;
          cap_b <= mat_b;
          rem <= L + 1;
        end
      end else if (abort && rem > 1) rem <= 0;
      else begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          for (int r = 0; r < SA; r++)
            for (int c = 0; c < SC; c++) exp_out[r][c] <= model_el(r, c);
        end
      end
    end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(rem > 0));
    check("done", int'(done), int'(m_done));
    for (int r = 0; r < SA; r++)
      for (int c = 0; c < SC; c++) check("mat_out", int'(mat_out[r][c]), int'(exp_out[r][c]));
  end

  task automatic scramble();
    for (int r = 0; r < SA; r++)
      for (int q = 0; q < SB; q++) mat_a[r][q] = NA'($urandom);
    for (int q = 0; q < SB; q++)
      for (int c = 0; c < SC; c++) mat_b[q][c] = NB'($urandom);
  endtask

  task automatic run(output int n_done);
    start = 1'b1;
    n_done = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        start = 1'b0;
        scramble();
      end
      if (done) begin
        n_done = n;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mat_a = '{'{0, 0}, '{0, 0}};
    mat_b = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
    #1 rst = 1'b1;
    #20;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out", int'(mat_out[1][3]), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    mat_a = '{'{16, 0}, '{0, 16}};
    mat_b = '{'{3, -4, 1, 0}, '{5, 7, 0, 2}};
    run(lat);
    check("ident_latency", lat, 9);
    check("ident_00", int'(mat_out[0][0]), 3);
    check("ident_01", int'(mat_out[0][1]), -4);
    check("ident_13", int'(mat_out[1][3]), 2);
    mat_a = '{'{16, 32}, '{48, 64}};
    mat_b = '{'{5, 6, 1, 0}, '{7, 8, 0, 1}};
    run(lat);
    check("prod_latency", lat, 9);
    check("prod_00", int'(mat_out[0][0]), 19);
    check("prod_01", int'(mat_out[0][1]), 22);
    check("prod_10", int'(mat_out[1][0]), 43);
    check("prod_11", int'(mat_out[1][1]), 50);
    check("prod_03", int'(mat_out[0][3]), 2);
    check("prod_12", int'(mat_out[1][2]), 3);
    mat_a = '{'{-24, 0}, '{0, 8}};
    mat_b = '{'{1, 0, 0, 0}, '{0, 1, -1, 0}};
    run(lat);
    check("round_neg", int'(mat_out[0][0]), -1);
    check("round_pos", int'(mat_out[1][1]), 1);
    check("round_half_neg", int'(mat_out[1][2]), 0);
    mat_a = '{'{-128, -128}, '{-128, -128}};
    mat_b = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128}};
    run(lat);
    check("extreme_00", int'(mat_out[0][0]), 2048);
    check("extreme_13", int'(mat_out[1][3]), 2048);
    mat_a = '{'{16, 32}, '{48, 64}};
    mat_b = '{'{5, 6, 1, 0}, '{7, 8, 0, 1}};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    dn = 0;
    for (int n = 0; n < L + 4; n++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_keep", int'(mat_out[0][0]), 2048);
    mat_a = '{'{16, 0}, '{0, 16}};
    mat_b = '{'{3, -4, 1, 0}, '{5, 7, 0, 2}};
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("held_first", d1, 9);
    check("held_spacing", d2 - d1, L + 2);
    check("held_01", int'(mat_out[0][1]), -4);
    mat_a = '{'{16, 32}, '{48, 64}};
    mat_b = '{'{5, 6, 1, 0}, '{7, 8, 0, 1}};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_out00", int'(mat_out[0][0]), 0);
    check("arst_out01", int'(mat_out[0][1]), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    run(lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_00", int'(mat_out[0][0]), 19);
    check("post_rst_11", int'(mat_out[1][1]), 50);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
